// File: rtl/elevator_scheduler.sv
// elevator_scheduler
//   Request scheduler and motion sequencer for a 3-floor elevator.
//   - Call buttons are latched into a pending-request register.
//   - A directional (SCAN-style) state machine moves the car one floor per
//     TRAVEL_CYCLES and holds the doors open DOOR_CYCLES at each stop.
//   - This block is the single owner of the current_floor register.
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   call_btn[2:0]  call request per floor (bit0 = 1st floor), level, sampled every cycle
//   pending[2:0]   latched outstanding requests (request LEDs)
//   current_floor  00 = 1st, 01 = 2nd, 10 = 3rd (11 never driven)
//   up_led         car moving up
//   down_led       car moving down
//   door_open      doors open
module elevator_scheduler #(
  parameter logic [15:0] TRAVEL_CYCLES = 16'd8,
  parameter logic [15:0] DOOR_CYCLES   = 16'd6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] call_btn,
  output logic [2:0] pending,
  output logic [1:0] current_floor,
  output logic       up_led,
  output logic       down_led,
  output logic       door_open
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] timer;
  logic [15:0] timer_nxt;
  logic [1:0]  floor_nxt;
  logic [1:0]  arrive;
  logic        last_up;
  logic        last_up_nxt;
  logic [2:0]  clr;
  logic [2:0]  pending_nxt;

  // Any request strictly above floor f.
  function automatic logic req_above(input logic [1:0] f, input logic [2:0] p);
    case (f)
      2'd0:    return p[1] | p[2];
      2'd1:    return p[2];
      default: return 1'b0;
    endcase
  endfunction

  // Any request strictly below floor f.
  function automatic logic req_below(input logic [1:0] f, input logic [2:0] p);
    case (f)
      2'd1:    return p[0];
      2'd2:    return p[0] | p[1];
      default: return 1'b0;
    endcase
  endfunction

  // One-hot mask for floor f; the unused code 11 maps to no floor.
  function automatic logic [2:0] floor_mask(input logic [1:0] f);
    case (f)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic req_at(input logic [1:0] f, input logic [2:0] p);
    return |(floor_mask(f) & p);
  endfunction

  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    floor_nxt   = current_floor;
    last_up_nxt = last_up;
    clr         = 3'b000;
    arrive      = current_floor;

    case (state)
      IDLE: begin
        timer_nxt = 16'd0;
        if (req_at(current_floor, pending)) begin
          state_nxt = DOOR_OPEN;
          timer_nxt = DOOR_CYCLES - 16'd1;
          clr       = floor_mask(current_floor);
        end else if (last_up && req_above(current_floor, pending)) begin
          state_nxt   = MOVE_UP;
          timer_nxt   = TRAVEL_CYCLES - 16'd1;
          last_up_nxt = 1'b1;
        end else if (req_below(current_floor, pending)) begin
          state_nxt   = MOVE_DOWN;
          timer_nxt   = TRAVEL_CYCLES - 16'd1;
          last_up_nxt = 1'b0;
        end else if (req_above(current_floor, pending)) begin
          state_nxt   = MOVE_UP;
          timer_nxt   = TRAVEL_CYCLES - 16'd1;
          last_up_nxt = 1'b1;
        end
      end

      MOVE_UP: begin
        if (timer == 16'd0) begin
          // Saturate at the top floor so current_floor can never wrap.
          arrive    = (current_floor >= 2'd2) ? 2'd2 : current_floor + 2'd1;
          floor_nxt = arrive;
          if (req_at(arrive, pending)) begin
            state_nxt = DOOR_OPEN;
            timer_nxt = DOOR_CYCLES - 16'd1;
            clr       = floor_mask(arrive);
          end else if (req_above(arrive, pending)) begin
            timer_nxt = TRAVEL_CYCLES - 16'd1;
          end else begin
            state_nxt = IDLE;
            timer_nxt = 16'd0;
          end
        end else begin
          timer_nxt = timer - 16'd1;
        end
      end

      MOVE_DOWN: begin
        if (timer == 16'd0) begin
          arrive    = (current_floor == 2'd0) ? 2'd0 : current_floor - 2'd1;
          floor_nxt = arrive;
          if (req_at(arrive, pending)) begin
            state_nxt = DOOR_OPEN;
            timer_nxt = DOOR_CYCLES - 16'd1;
            clr       = floor_mask(arrive);
          end else if (req_below(arrive, pending)) begin
            timer_nxt = TRAVEL_CYCLES - 16'd1;
          end else begin
            state_nxt = IDLE;
            timer_nxt = 16'd0;
          end
        end else begin
          timer_nxt = timer - 16'd1;
        end
      end

      DOOR_OPEN: begin
        // Presses at the open floor are absorbed without extending the door time.
        clr = floor_mask(current_floor);
        if (timer == 16'd0) begin
          state_nxt = IDLE;
          timer_nxt = 16'd0;
        end else begin
          timer_nxt = timer - 16'd1;
        end
      end

      default: begin
        state_nxt = IDLE;
        timer_nxt = 16'd0;
      end
    endcase
  end

  // Clear wins over a simultaneous set.
  assign pending_nxt = (pending | call_btn) & ~clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      timer         <= 16'd0;
      current_floor <= 2'd0;
      last_up       <= 1'b1;
      pending       <= 3'b000;
    end else begin
      state         <= state_nxt;
      timer         <= timer_nxt;
      current_floor <= floor_nxt;
      last_up       <= last_up_nxt;
      pending       <= pending_nxt;
    end
  end

  assign up_led    = (state == MOVE_UP);
  assign down_led  = (state == MOVE_DOWN);
  assign door_open = (state == DOOR_OPEN);

endmodule

// File: tb/tb_elevator_scheduler.sv
module tb_elevator_scheduler;

  localparam int TRAVEL = 4;
  localparam int DOOR   = 3;

  logic       clk;
  logic       rst_n;
  logic [2:0] call_btn;
  logic [2:0] pending;
  logic [1:0] current_floor;
  logic       up_led;
  logic       down_led;
  logic       door_open;

  elevator_scheduler #(
    .TRAVEL_CYCLES(16'(TRAVEL)),
    .DOOR_CYCLES  (16'(DOOR))
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .call_btn     (call_btn),
    .pending      (pending),
    .current_floor(current_floor),
    .up_led       (up_led),
    .down_led     (down_led),
    .door_open    (door_open)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit started = 1'b0;
  logic [7:0] exp_q[$];

  // ---------------- reference model ----------------
  // Car described by floor number, travel direction (+1/-1/0), door flag and
  // the number of cycles left in the current activity.
  bit [2:0] m_req;
  int       m_floor;
  int       m_dir;
  int       m_pref;
  int       m_left;
  bit       m_door;

  function automatic bit any_above(input int f, input bit [2:0] r);
    for (int i = f + 1; i < 3; i++) if (r[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit any_below(input int f, input bit [2:0] r);
    for (int i = 0; i < f; i++) if (r[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_req = 3'b000; m_floor = 0; m_dir = 0; m_pref = 1; m_left = 0; m_door = 1'b0;
  endtask

  task automatic model_start(input int d);
    m_dir = d; m_pref = d; m_left = TRAVEL;
  endtask

  task automatic model_step(input bit [2:0] c);
    bit [2:0] clr;
    bit [2:0] old;
    clr = 3'b000;
    old = m_req;
    if (m_door) begin
      clr[m_floor] = 1'b1;
      m_left--;
      if (m_left == 0) m_door = 1'b0;
    end else if (m_dir != 0) begin
      m_left--;
      if (m_left == 0) begin
        m_floor += m_dir;
        if (old[m_floor]) begin
          m_door = 1'b1; m_left = DOOR; clr[m_floor] = 1'b1; m_dir = 0;
        end else if ((m_dir > 0 && any_above(m_floor, old)) ||
                     (m_dir < 0 && any_below(m_floor, old))) begin
          m_left = TRAVEL;
        end else begin
          m_dir = 0;
        end
      end
    end else begin
      if (old[m_floor]) begin
        m_door = 1'b1; m_left = DOOR; clr[m_floor] = 1'b1;
      end else if (m_pref > 0 && any_above(m_floor, old)) model_start(1);
      else if (any_below(m_floor, old)) model_start(-1);
      else if (any_above(m_floor, old)) model_start(1);
    end
    m_req = (old | c) & ~clr;
  endtask

  function automatic logic [7:0] model_out();
    logic [1:0] f;
    f = 2'(m_floor);
    return {m_req, f, (m_dir == 1), (m_dir == -1), m_door};
  endfunction

  // ---------------- driver ----------------
  // Drives one cycle's inputs at the falling edge and pushes what the
  // outputs must be after the following rising edge.
  task automatic cycle(input logic [2:0] c, input bit rst);
    logic [7:0] act;
    @(negedge clk);
    call_btn = c;
    if (rst) begin
      bit was_running;
      was_running = rst_n;
      rst_n = 1'b0;
      model_reset();
      exp_q.push_back(model_out());
      started = 1'b1;
      if (was_running) begin
        #1;
        act = {pending, current_floor, up_led, down_led, door_open};
        vectors++;
        if (act !== 8'h00) begin
          miscompares++;
          $display("FAIL async_reset: got %b required 00000000", act);
        end
      end
    end else begin
      rst_n = 1'b1;
      model_step(c);
      exp_q.push_back(model_out());
      started = 1'b1;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(3'b000, 1'b0);
  endtask

  task automatic wait_state(input int floor, input int dir, input bit door, input string what);
    int budget;
    budget = 200;
    while (!(m_floor == floor && m_dir == dir && m_door == door) && budget > 0) begin
      cycle(3'b000, 1'b0);
      budget--;
    end
    if (budget == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout_%s: floor %0d dir %0d door %0d required floor %0d dir %0d door %0d",
               what, m_floor, m_dir, m_door, floor, dir, door);
    end
  endtask

  // ---------------- monitor ----------------
  int cyc = 0;
  always @(posedge clk) begin
    logic [7:0] act;
    logic [7:0] exp;
    #1;
    cyc++;
    if (started) begin
      act = {pending, current_floor, up_led, down_led, door_open};
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard_empty cycle %0d: got %b required a queued entry", cyc, act);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          miscompares++;
          $display("FAIL outputs cycle %0d {pend,floor,up,dn,door}: got %b required %b",
                   cyc, act, exp);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    call_btn = 3'b000;
    model_reset();
    cycle(3'b000, 1'b1);
    cycle(3'b000, 1'b1);
    idle_cycles(3);

    // Reset asserted mid-MOVE_UP at floor 01, then no motion after release.
    cycle(3'b100, 1'b0);
    wait_state(1, 1, 1'b0, "reach_floor1_up");
    cycle(3'b000, 1'b1);
    cycle(3'b000, 1'b1);
    idle_cycles(6);

    // Single up trip 00 -> 10.
    cycle(3'b100, 1'b0);
    idle_cycles(16);

    // Go to 01, then same-floor call there.
    cycle(3'b010, 1'b0);
    idle_cycles(14);
    cycle(3'b010, 1'b0);
    idle_cycles(8);

    // Back to 00, then intermediate stop at 01 on the way to 10.
    cycle(3'b001, 1'b0);
    idle_cycles(14);
    cycle(3'b100, 1'b0);
    idle_cycles(2);
    cycle(3'b010, 1'b0);
    idle_cycles(24);

    // Direction persistence: at 01 after moving up, 001 and 100 both pending.
    cycle(3'b001, 1'b0);
    idle_cycles(16);
    cycle(3'b110, 1'b0);
    wait_state(1, 0, 1'b1, "door_at_floor1");
    cycle(3'b001, 1'b0);
    idle_cycles(40);

    // Press held at the open floor while the door is open at 10.
    cycle(3'b100, 1'b0);
    wait_state(2, 0, 1'b1, "door_at_floor2");
    for (int i = 0; i < 4; i++) cycle(3'b100, 1'b0);
    idle_cycles(10);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        cycle(3'b000, 1'b1);
      end else if ($urandom_range(0, 7) == 0) begin
        cycle(3'($urandom_range(1, 7)), 1'b0);
      end else begin
        cycle(3'b000, 1'b0);
      end
    end
    idle_cycles(30);

    @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
